// File: rtl/itr_ctrl.sv
// itr_ctrl: edge-latched, maskable, nested vectored interrupt controller in front of the core.
// Latency: irq rising edge to itr is 2 cycles; ack/ret update state on the sampling edge.
// Backpressure: once raised, itr and a frozen itr_addr are held until the core pulses itr_ack.
module itr_ctrl #(
  parameter int NCHAN  = 4,
  parameter int MINSTW = 9,
  parameter int VBASE  = 1,
  parameter int VSTEP  = 2,
  parameter int NESTD  = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NCHAN-1:0]             irq,
  input  logic                         mask_wr,
  input  logic [NCHAN-1:0]             mask_in,
  input  logic                         itr_ack,
  input  logic                         itr_ret,
  output logic                         itr,
  output logic [MINSTW-1:0]            itr_addr,
  output logic [NCHAN-1:0]             mask,
  output logic [NCHAN-1:0]             pend,
  output logic [NCHAN-1:0]             in_serv,
  output logic [$clog2(NESTD+1)-1:0]   depth
);

  localparam int CW = (NCHAN > 1) ? $clog2(NCHAN) : 1;
  localparam int DW = $clog2(NESTD+1);
  localparam logic [DW-1:0] NESTD_W = DW'(NESTD);

  // Result of a lowest-set-bit search: whether any bit was set, and its index.
  typedef struct packed {
    logic          vld;
    logic [CW-1:0] idx;
  } pick_t;

  typedef enum logic {IDLE, REQ} state_t;

  state_t           state_q, state_d;
  logic [NCHAN-1:0] irq_q;
  logic [CW-1:0]    ch_q;
  logic [NCHAN-1:0] rise, elig, ack_hot, ret_hot;
  logic [NCHAN-1:0] pend_d, serv_d;
  logic [DW-1:0]    depth_d;
  pick_t            cand, lvl;
  logic             req_ok, take, ack_fire;

  // Lowest index wins: channel 0 is the highest priority.
  function automatic pick_t lowest(input logic [NCHAN-1:0] v);
    pick_t p;
    p = '0;
    for (int i = NCHAN-1; i >= 0; i--) begin
      if (v[i]) begin
        p.vld = 1'b1;
        p.idx = CW'(i);
      end
    end
    return p;
  endfunction

  // Vector address wraps modulo the instruction address space.
  function automatic logic [MINSTW-1:0] vec_of(input logic [CW-1:0] c);
    logic [31:0] v;
    v = 32'(VBASE) + 32'(c) * 32'(VSTEP);
    return v[MINSTW-1:0];
  endfunction

  // Arbitration: best eligible channel must outrank the current service level and fit the nesting budget.
  always_comb begin
    rise   = irq & ~irq_q;
    elig   = pend & mask;
    cand   = lowest(elig);
    lvl    = lowest(in_serv);
    req_ok = cand.vld && (!lvl.vld || (cand.idx < lvl.idx)) && (depth < NESTD_W);
  end

  // Request FSM next state: latch a vector from IDLE, hold it in REQ until acknowledged.
  always_comb begin
    state_d  = state_q;
    take     = 1'b0;
    ack_fire = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_ok) begin
          state_d = REQ;
          take    = 1'b1;
        end
      end
      REQ: begin
        if (itr_ack) begin
          state_d  = IDLE;
          ack_fire = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Status next values: ret retires the old lowest level before ack adds ch; a fresh edge beats the ack clear.
  always_comb begin
    ack_hot = '0;
    ret_hot = '0;
    if (ack_fire) begin
      ack_hot[ch_q] = 1'b1;
    end
    if (itr_ret && lvl.vld) begin
      ret_hot[lvl.idx] = 1'b1;
    end
    pend_d  = (pend & ~ack_hot) | rise;
    serv_d  = (in_serv & ~ret_hot) | ack_hot;
    depth_d = '0;
    for (int i = 0; i < NCHAN; i++) begin
      depth_d = depth_d + DW'(serv_d[i]);
    end
  end

  // FSM state and the frozen channel/vector presented to the core.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      ch_q     <= '0;
      itr_addr <= '0;
    end else begin
      state_q <= state_d;
      if (take) begin
        ch_q     <= cand.idx;
        itr_addr <= vec_of(cand.idx);
      end
    end
  end

  // Edge detector, pending latch, mask register and in-service tracking.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      irq_q   <= '0;
      pend    <= '0;
      mask    <= '0;
      in_serv <= '0;
      depth   <= '0;
    end else begin
      irq_q   <= irq;
      pend    <= pend_d;
      in_serv <= serv_d;
      depth   <= depth_d;
      if (mask_wr) begin
        mask <= mask_in;
      end
    end
  end

  assign itr = (state_q == REQ);

endmodule

// File: doc/itr_ctrl.md
# itr_ctrl

Multi-channel vectored interrupt controller placed between external event lines and the processor core's single `itr` request / interrupt-address path. It generalises the core's one fixed interrupt address to NCHAN prioritised, maskable, edge-triggered channels. Each channel has its own vector. Higher-priority channels may preempt lower ones, up to a programmable nesting depth. The block latches events, arbitrates, and presents a stable vector to the core until acknowledged. It tracks in-service levels until the core signals return.

## Interface
- NCHAN, 4: number of interrupt channels (≥2); channel 0 highest priority.
- MINSTW, 9: instruction address width; width of `itr_addr`.
- VBASE, 1: vector address of channel 0.
- VSTEP, 2: address spacing between consecutive channel vectors.
- NESTD, 2: maximum simultaneous in-service levels (≥1).
- clk  in  1  system clock; all state on rising edge.
- rst  in  1  asynchronous, active-low reset (0 = reset asserted).
- irq  in  NCHAN  raw event lines, synchronous to clk; rising edge = event.
- mask_wr  in  1  load `mask_in` into mask register.
- mask_in  in  NCHAN  new enable mask (1 = enabled).
- itr_ack  in  1  one-cycle pulse: core has taken the presented vector.
- itr_ret  in  1  one-cycle pulse: core executed return-from-interrupt.
- itr  out  1  interrupt request to core.
- itr_addr  out  MINSTW  vector of requested channel, valid while `itr`=1.
- mask  out  NCHAN  current enable mask.
- pend  out  NCHAN  latched pending events.
- in_serv  out  NCHAN  channels currently in service.
- depth  out  $clog2(NESTD+1)  popcount of `in_serv`.

## Operation
- Edge detect: `irq_q` registers `irq`; `pend[i]` is set on the edge where `irq[i]`=1 and `irq_q[i]`=0. Level-high `irq` sets `pend` only once.
- Pending is independent of mask: a masked event stays pending and becomes eligible when unmasked.
- Eligible set: `pend & mask`.
- Candidate: lowest-index eligible channel c.
- Current level L: lowest set index of `in_serv`, or none.
- Request allowed when c exists, (`in_serv`=0 or c < L), and `depth` < NESTD.
- FSM IDLE: when request allowed, register ch←c and `itr_addr`←(VBASE + c·VSTEP) mod 2^MINSTW, then go to REQ.
- FSM REQ: `itr`=1; ch and `itr_addr` frozen. Later higher-priority events or mask changes do not alter the presented vector.
- FSM REQ, on `itr_ack`: clear `pend[ch]`, set `in_serv[ch]`, go to IDLE.
- `itr_ack` in IDLE is ignored.
- `itr_ret`: clears the lowest set bit of `in_serv`. Ignored when `in_serv`=0.
- `mask_wr`: mask←`mask_in` on that edge.
- Simultaneous events on the same edge:
  - new edge on `irq[ch]` + ack of ch: pend stays 1 (set wins).
  - `itr_ret` + `itr_ack`: ret clears lowest bit of old `in_serv` first, then ack sets ch.
  - `mask_wr` + arbitration: IDLE decision uses the old mask.
- Reset (any time, including in REQ): `itr`=0, `itr_addr`=0, `mask`=0, `pend`=0, `in_serv`=0, `depth`=0, `irq_q`=0, FSM=IDLE. Takes effect immediately (asynchronous). Events arriving while `rst`=0 are lost.

## Timing
- `irq[i]` first high at edge k → `pend[i]`=1 after k → FSM REQ, `itr`=1 with valid `itr_addr` after k+1. Irq-to-request latency is 2 cycles.
- `itr_ack` sampled at edge m → `itr`=0, `in_serv`/`pend`/`depth` updated after m. The earliest next `itr` is after m+1, so there is at least 1 low cycle between requests.
- `itr_ret` at edge r → `in_serv`/`depth` updated after r. A newly allowed lower-priority request is asserted after r+1.
- All outputs registered; no combinational input-to-output path.

## Test plan
- NCHAN=4, VBASE=16, VSTEP=4, NESTD=2, mask=4'b1111.
  - Pulse `irq[2]` → `itr`=1 exactly 2 cycles later with `itr_addr`=24.
  - Ack → `in_serv`=4'b0100, `depth`=1, `pend`=0.
- Preemption and nesting limit:
  - With ch2 in service, edge on `irq[3]` → no `itr` (lower priority).
  - Edge on `irq[1]` → `itr_addr`=20; ack → `in_serv`=4'b0110, `depth`=2.
  - Edge on `irq[0]` → no `itr` while `depth`=2.
  - `itr_ret` → `in_serv`=4'b0100 and ch0 requested with `itr_addr`=16.
- Masking: mask=4'b1110, edge on `irq[0]` → `pend`=4'b0001 and no `itr`. Write mask=4'b1111 → `itr` asserted 2 cycles after the write edge with `itr_addr`=16.
- Frozen vector: in REQ for ch3 (`itr_addr`=28), raise `irq[0]` → `itr_addr` stays 28 until ack. Then ch0 is requested after the 1-cycle gap.
- Corner cases:
  - Ack coincident with a new `irq[ch]` edge → `pend[ch]` stays 1.
  - `itr_ret` with `in_serv`=0 → no change.
  - `itr_ack` in IDLE → no change.
- Reset: drive `rst`=0 asynchronously mid-REQ → `itr`, `itr_addr`, `pend`, `in_serv`, `mask` all 0 without waiting for a clock edge. FSM is IDLE after release.
